sent_rx_frame_check: RTL and testbench
======================================

Name: sent_rx_frame_check

Overview:
- Downstream of the SENT RX pulse checker, in the clk_rx domain.
- Consumes one strobe per measured pulse: a sync/calibration strobe, or a decoded nibble strobe carrying a 4-bit value.
- Assembles each fast-channel frame: 1 status nibble, DATA_NIBBLES data nibbles, 1 CRC nibble.
- Checks the SAE J2716 CRC-4 and presents the frame with status flags and a saturating error counter.

Parameters:
- DATA_NIBBLES, 6: data nibbles per frame, legal range 1..6.
- CRC_SEED, 4'b0101: CRC-4 initial value.
- ERR_CNT_W, 8: width of the saturating error counter.

Ports:
- clk_rx  in  1  receive clock; all logic rising-edge.
- reset  in  1  asynchronous, active-high.
- sync_valid  in  1  one-cycle strobe: calibration/sync pulse detected.
- nibble_valid  in  1  one-cycle strobe: nibble pulse measured.
- nibble_value  in  4  nibble value, qualified by nibble_valid.
- pulse_error  in  1  one-cycle strobe: upstream pulse length out of range.
- frame_valid  out  1  one-cycle strobe: frame outputs updated.
- frame_status  out  4  status/communication nibble.
- frame_data  out  24  data nibbles, first nibble in MSBs, right-aligned to 4*DATA_NIBBLES bits, upper bits 0.
- frame_crc  out  4  received CRC nibble.
- crc_ok  out  1  frame_crc matched the computed CRC.
- frame_abort  out  1  one-cycle strobe: frame discarded.
- err_count  out  ERR_CNT_W  saturating count of CRC failures plus aborts.

Behaviour:
- Reset:
  - All outputs 0, state WAIT_SYNC, nibble counter 0, CRC register = CRC_SEED.
  - Reset mid-frame discards the partial frame without a frame_abort pulse.
- WAIT_SYNC:
  - nibble_valid and pulse_error are ignored; this covers pause pulses and garbage.
  - sync_valid -> STATUS.
- STATUS:
  - On nibble_valid: latch nibble into the status shadow, load CRC register = CRC_SEED, go to DATA with index 0.
- DATA:
  - Each nibble_valid shifts the nibble into the data shadow and updates the CRC register.
  - CRC update: crc <= T(crc) ^ nibble, where T(v) = (v * x^4) mod (x^4+x^3+x^2+1).
  - Equivalently, T(v) is the XOR of these terms, one per set bit of v:
    - bit3 -> 0001
    - bit2 -> 1110
    - bit1 -> 0111
    - bit0 -> 1101
  - After nibble number DATA_NIBBLES -> CRC.
- CRC:
  - On nibble_valid, compute expected = T(crc_reg); this is the augmentation with a zero nibble.
  - Status nibble is excluded from the CRC.
  - Next cycle:
    - frame_valid = 1.
    - frame_status, frame_data and frame_crc are loaded from the shadows.
    - crc_ok = (nibble == expected).
    - Go to WAIT_SYNC.
- Latency:
  - frame_valid is asserted exactly 1 clk_rx cycle after the CRC nibble strobe.
  - Outputs hold until the next frame_valid.
- Abort conditions:
  - sync_valid while in STATUS/DATA/CRC: frame_abort for 1 cycle, err_count += 1, restart at STATUS (this sync begins the new frame).
  - pulse_error while in STATUS/DATA/CRC: frame_abort, err_count += 1, go to WAIT_SYNC.
  - Frame outputs are untouched on abort.
- Simultaneous strobes:
  - sync_valid has priority over nibble_valid; the nibble is dropped.
  - pulse_error has priority over both.
- Error counter:
  - crc_ok = 0 on frame_valid increments err_count.
  - err_count saturates at all-ones, no wrap.
  - At most one increment per cycle.
- No back-pressure: the consumer must sample on frame_valid.

Decomposition:
- Shared package sent_rx_pkg holds:
  - State encoding: WAIT_SYNC, STATUS, DATA, CRC.
  - SENT_CRC_POLY.
  - SENT_CRC_SEED default.
  - SENT_MAX_DATA_NIBBLES = 6.
- One sub-module: sent_crc4_step. It is combinational, computes T(v) ^ n, and is reused for both the data update and the augmentation step.

Test Plan:
- Zero frame: sync, status 0, data 0,0,0,0,0,0, CRC 5 -> frame_valid 1 cycle later, frame_data 0x000000, crc_ok 1, err_count 0.
- Single-bit data: sync, status 3, data 0,0,0,0,0,1, CRC 8 -> frame_status 3, frame_data 0x000001, crc_ok 1.
- Bad CRC: same frame with CRC 9 -> crc_ok 0, err_count 1, frame_data still 0x000001.
- Resync mid-frame: sync, status, 3 data nibbles, sync, then full zero frame with CRC 5 -> one frame_abort, err_count 1, then valid frame with crc_ok 1.
- Pause and noise: nibble_valid strobes in WAIT_SYNC, and pulse_error during DATA -> no frame_valid, one frame_abort, state returns to WAIT_SYNC; next clean frame decodes.
- Saturation and reset: ERR_CNT_W=2, 5 bad-CRC frames -> err_count 3. Async reset mid-DATA -> all outputs 0 immediately, no frame_abort.

Source files
------------

// File: rtl/sent_rx_pkg.sv
// Shared definitions for the SENT receive frame path: FSM encoding and CRC-4 constants.
package sent_rx_pkg;

   typedef enum logic [1:0] {
      StWaitSync,
      StStatus,
      StData,
      StCrc
   } sent_state_e;

   // x^4 + x^3 + x^2 + 1 with the x^4 term implied
   localparam logic [3:0]  SENT_CRC_POLY         = 4'b1101;
   localparam logic [3:0]  SENT_CRC_SEED         = 4'b0101;
   localparam int unsigned SENT_MAX_DATA_NIBBLES = 6;
   localparam int unsigned SENT_DATA_W           = 4 * SENT_MAX_DATA_NIBBLES;

endpackage

// File: rtl/sent_crc4_step.sv
// One SAE J2716 CRC-4 step: crc_out = (crc_in * x^4 mod poly) ^ nibble.
module sent_crc4_step
   import sent_rx_pkg::*;
(
   input  logic [3:0] crc_in,
   input  logic [3:0] nibble,
   output logic [3:0] crc_out
);

   logic [3:0] shift_v;

   // Four shift-and-reduce rounds multiply by x^4 modulo the generator
   always_comb begin
      shift_v = crc_in;
      for (int i = 0; i < 4; i++) begin
         if (shift_v[3]) begin
            shift_v = {shift_v[2:0], 1'b0} ^ SENT_CRC_POLY;
         end else begin
            shift_v = {shift_v[2:0], 1'b0};
         end
      end
      crc_out = shift_v ^ nibble;
   end

endmodule

// File: rtl/sent_rx_frame_check.sv
// SENT fast-channel frame assembler: collects status/data/CRC nibbles after a sync pulse,
// checks the CRC-4 and reports frames, aborts and a saturating error count.
module sent_rx_frame_check
   import sent_rx_pkg::*;
#(
   parameter int unsigned DATA_NIBBLES = 6,
   parameter logic [3:0]  CRC_SEED     = SENT_CRC_SEED,
   parameter int unsigned ERR_CNT_W    = 8
) (
   input  logic                   clk_rx,
   input  logic                   reset,
   input  logic                   sync_valid,
   input  logic                   nibble_valid,
   input  logic [3:0]             nibble_value,
   input  logic                   pulse_error,
   output logic                   frame_valid,
   output logic [3:0]             frame_status,
   output logic [SENT_DATA_W-1:0] frame_data,
   output logic [3:0]             frame_crc,
   output logic                   crc_ok,
   output logic                   frame_abort,
   output logic [ERR_CNT_W-1:0]   err_count
);

   sent_state_e            state_q, state_d;
   logic [2:0]             idx_q, idx_d;
   logic [3:0]             crc_q, crc_d;
   logic [3:0]             status_sh_q, status_sh_d;
   logic [SENT_DATA_W-1:0] data_sh_q, data_sh_d;
   logic                   frame_valid_q, frame_valid_d;
   logic [3:0]             frame_status_q, frame_status_d;
   logic [SENT_DATA_W-1:0] frame_data_q, frame_data_d;
   logic [3:0]             frame_crc_q, frame_crc_d;
   logic                   crc_ok_q, crc_ok_d;
   logic                   frame_abort_q, frame_abort_d;
   logic [ERR_CNT_W-1:0]   err_count_q, err_count_d;

   logic       in_frame, abort, nib_take, last_nibble, err_inc;
   logic [3:0] crc_upd, crc_exp;

   sent_crc4_step u_crc_data (
      .crc_in  (crc_q),
      .nibble  (nibble_value),
      .crc_out (crc_upd)
   );

   // Augmentation with a zero nibble yields the expected CRC
   sent_crc4_step u_crc_aug (
      .crc_in  (crc_q),
      .nibble  (4'h0),
      .crc_out (crc_exp)
   );

   assign in_frame    = (state_q != StWaitSync);
   assign abort       = in_frame & (pulse_error | sync_valid);
   assign nib_take    = nibble_valid & ~pulse_error & ~sync_valid;
   assign last_nibble = (idx_q == 3'(DATA_NIBBLES - 1));

   always_ff @(posedge clk_rx or posedge reset) begin
      if (reset) begin
         state_q <= StWaitSync;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (in_frame && pulse_error) begin
         state_d = StWaitSync;
      end else if (sync_valid) begin
         state_d = StStatus;
      end else if (nibble_valid) begin
         unique case (state_q)
            StWaitSync: state_d = StWaitSync;
            StStatus:   state_d = StData;
            StData:     state_d = last_nibble ? StCrc : StData;
            StCrc:      state_d = StWaitSync;
            default:    state_d = StWaitSync;
         endcase
      end
   end

   always_comb begin
      idx_d          = idx_q;
      crc_d          = crc_q;
      status_sh_d    = status_sh_q;
      data_sh_d      = data_sh_q;
      frame_valid_d  = 1'b0;
      frame_status_d = frame_status_q;
      frame_data_d   = frame_data_q;
      frame_crc_d    = frame_crc_q;
      crc_ok_d       = crc_ok_q;
      frame_abort_d  = abort;
      err_inc        = abort;
      if (nib_take) begin
         unique case (state_q)
            StWaitSync: ;
            StStatus: begin
               status_sh_d = nibble_value;
               data_sh_d   = '0;
               crc_d       = CRC_SEED;
               idx_d       = '0;
            end
            StData: begin
               data_sh_d = {data_sh_q[SENT_DATA_W-5:0], nibble_value};
               crc_d     = crc_upd;
               idx_d     = idx_q + 3'd1;
            end
            StCrc: begin
               frame_valid_d  = 1'b1;
               frame_status_d = status_sh_q;
               frame_data_d   = data_sh_q;
               frame_crc_d    = nibble_value;
               crc_ok_d       = (nibble_value == crc_exp);
               err_inc        = (nibble_value != crc_exp);
            end
            default: ;
         endcase
      end
      err_count_d = (err_inc && (err_count_q != '1)) ? err_count_q + ERR_CNT_W'(1) : err_count_q;
   end

   always_ff @(posedge clk_rx or posedge reset) begin
      if (reset) begin
         idx_q          <= '0;
         crc_q          <= CRC_SEED;
         status_sh_q    <= '0;
         data_sh_q      <= '0;
         frame_valid_q  <= 1'b0;
         frame_status_q <= '0;
         frame_data_q   <= '0;
         frame_crc_q    <= '0;
         crc_ok_q       <= 1'b0;
         frame_abort_q  <= 1'b0;
         err_count_q    <= '0;
      end else begin
         idx_q          <= idx_d;
         crc_q          <= crc_d;
         status_sh_q    <= status_sh_d;
         data_sh_q      <= data_sh_d;
         frame_valid_q  <= frame_valid_d;
         frame_status_q <= frame_status_d;
         frame_data_q   <= frame_data_d;
         frame_crc_q    <= frame_crc_d;
         crc_ok_q       <= crc_ok_d;
         frame_abort_q  <= frame_abort_d;
         err_count_q    <= err_count_d;
      end
   end

   assign frame_valid  = frame_valid_q;
   assign frame_status = frame_status_q;
   assign frame_data   = frame_data_q;
   assign frame_crc    = frame_crc_q;
   assign crc_ok       = crc_ok_q;
   assign frame_abort  = frame_abort_q;
   assign err_count    = err_count_q;

endmodule

// File: tb/tb_sent_rx_frame_check.sv
// Bench for sent_rx_frame_check: table-driven frames, scoreboarded frame outputs and
// hand-written abort, noise, saturation and reset sequences.
module tb_sent_rx_frame_check;

   logic        clk_rx = 1'b0;
   logic        reset;
   logic        sync_valid, nibble_valid, pulse_error;
   logic [3:0]  nibble_value;
   logic        frame_valid, crc_ok, frame_abort;
   logic [3:0]  frame_status, frame_crc;
   logic [23:0] frame_data;
   logic [7:0]  err_count;
   logic        s_frame_valid, s_crc_ok, s_frame_abort;
   logic [3:0]  s_frame_status, s_frame_crc;
   logic [23:0] s_frame_data;
   logic [1:0]  s_err_count;

   always #5 clk_rx = ~clk_rx;

   sent_rx_frame_check #(
      .DATA_NIBBLES (6),
      .CRC_SEED     (4'b0101),
      .ERR_CNT_W    (8)
   ) dut (
      .clk_rx       (clk_rx),
      .reset        (reset),
      .sync_valid   (sync_valid),
      .nibble_valid (nibble_valid),
      .nibble_value (nibble_value),
      .pulse_error  (pulse_error),
      .frame_valid  (frame_valid),
      .frame_status (frame_status),
      .frame_data   (frame_data),
      .frame_crc    (frame_crc),
      .crc_ok       (crc_ok),
      .frame_abort  (frame_abort),
      .err_count    (err_count)
   );

   sent_rx_frame_check #(
      .DATA_NIBBLES (6),
      .CRC_SEED     (4'b0101),
      .ERR_CNT_W    (2)
   ) dut_sat (
      .clk_rx       (clk_rx),
      .reset        (reset),
      .sync_valid   (sync_valid),
      .nibble_valid (nibble_valid),
      .nibble_value (nibble_value),
      .pulse_error  (pulse_error),
      .frame_valid  (s_frame_valid),
      .frame_status (s_frame_status),
      .frame_data   (s_frame_data),
      .frame_crc    (s_frame_crc),
      .crc_ok       (s_crc_ok),
      .frame_abort  (s_frame_abort),
      .err_count    (s_err_count)
   );

   typedef struct {
      logic [3:0]  status;
      logic [23:0] data;
      logic [3:0]  crc;
      logic        ok;
   } frame_t;

   typedef struct {
      logic [3:0]  status;
      logic [23:0] data;
      logic [3:0]  crc;
      logic        ok;
      int          err;
   } vec_t;

   frame_t exp_q[$];
   frame_t mon_e;
   vec_t   vecs[5];
   int     checks = 0;
   int     failures = 0;
   int     abort_cnt = 0;
   int     base_ab;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Multiply by x^4 mod x^4+x^3+x^2+1 using the per-bit contribution table
   function automatic logic [3:0] t_model(input logic [3:0] v);
      logic [3:0] r;
      r = 4'h0;
      if (v[3]) r = r ^ 4'b0001;
      if (v[2]) r = r ^ 4'b1110;
      if (v[1]) r = r ^ 4'b0111;
      if (v[0]) r = r ^ 4'b1101;
      return r;
   endfunction

   function automatic logic [3:0] crc_model(input logic [23:0] d);
      logic [3:0] c;
      c = 4'b0101;
      for (int i = 5; i >= 0; i--) c = t_model(c) ^ d[4*i +: 4];
      return t_model(c);
   endfunction

   always @(negedge clk_rx) begin
      if (!reset && frame_abort) abort_cnt++;
      if (!reset && frame_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_frame_valid", 32'd1, 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("sb_frame_status", frame_status, mon_e.status);
            chk("sb_frame_data", frame_data, mon_e.data);
            chk("sb_frame_crc", frame_crc, mon_e.crc);
            chk("sb_crc_ok", crc_ok, mon_e.ok);
         end
      end
   end

   task automatic strobe(input logic s, input logic n, input logic [3:0] v, input logic pe);
      @(negedge clk_rx);
      sync_valid = s; nibble_valid = n; nibble_value = v; pulse_error = pe;
      @(negedge clk_rx);
      sync_valid = 1'b0; nibble_valid = 1'b0; pulse_error = 1'b0;
   endtask

   task automatic send_frame(input logic [3:0] st, input logic [23:0] d, input logic [3:0] c,
                             input logic ok, input bit do_sync);
      frame_t e;
      if (do_sync) strobe(1'b1, 1'b0, 4'h0, 1'b0);
      strobe(1'b0, 1'b1, st, 1'b0);
      for (int i = 5; i >= 0; i--) strobe(1'b0, 1'b1, d[4*i +: 4], 1'b0);
      e.status = st; e.data = d; e.crc = c; e.ok = ok;
      exp_q.push_back(e);
      strobe(1'b0, 1'b1, c, 1'b0);
      chk("frame_valid_latency", frame_valid, 32'd1);
      @(negedge clk_rx);
      chk("frame_valid_single_cycle", frame_valid, 32'd0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_frame_valid"}, frame_valid, 32'd0);
      chk({tag, "_frame_status"}, frame_status, 32'd0);
      chk({tag, "_frame_data"}, frame_data, 32'd0);
      chk({tag, "_frame_crc"}, frame_crc, 32'd0);
      chk({tag, "_crc_ok"}, crc_ok, 32'd0);
      chk({tag, "_frame_abort"}, frame_abort, 32'd0);
      chk({tag, "_err_count"}, err_count, 32'd0);
      chk({tag, "_sat_err_count"}, s_err_count, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      sync_valid = 1'b0; nibble_valid = 1'b0; nibble_value = 4'h0; pulse_error = 1'b0;
      vecs[0] = '{4'h0, 24'h000000, 4'h5, 1'b1, 0};
      vecs[1] = '{4'h3, 24'h000001, 4'h8, 1'b1, 0};
      vecs[2] = '{4'h3, 24'h000001, 4'h9, 1'b0, 1};
      vecs[3] = '{4'hA, 24'h123456, crc_model(24'h123456), 1'b1, 1};
      vecs[4] = '{4'hF, 24'hFEDCBA, crc_model(24'hFEDCBA) ^ 4'h1, 1'b0, 2};

      repeat (2) @(negedge clk_rx);
      chk_all_zero("reset");
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         send_frame(vecs[i].status, vecs[i].data, vecs[i].crc, vecs[i].ok, 1'b1);
         chk($sformatf("row%0d_err_count", i), err_count, vecs[i].err);
         chk($sformatf("row%0d_data_hold", i), frame_data, vecs[i].data);
      end

      // Resync in the middle of DATA: that sync starts the next frame
      base_ab = abort_cnt;
      strobe(1'b1, 1'b0, 4'h0, 1'b0);
      strobe(1'b0, 1'b1, 4'h7, 1'b0);
      for (int i = 0; i < 3; i++) strobe(1'b0, 1'b1, 4'h9, 1'b0);
      send_frame(4'h7, 24'h000000, 4'h5, 1'b1, 1'b1);
      chk("resync_abort_count", abort_cnt - base_ab, 32'd1);
      chk("resync_err_count", err_count, 32'd3);

      // Garbage while idle, then pulse_error inside DATA
      base_ab = abort_cnt;
      strobe(1'b0, 1'b1, 4'h4, 1'b0);
      strobe(1'b0, 1'b1, 4'hC, 1'b0);
      strobe(1'b0, 1'b0, 4'h0, 1'b1);
      strobe(1'b1, 1'b0, 4'h0, 1'b0);
      strobe(1'b0, 1'b1, 4'h2, 1'b0);
      strobe(1'b0, 1'b1, 4'h5, 1'b0);
      strobe(1'b0, 1'b1, 4'h6, 1'b0);
      strobe(1'b0, 1'b1, 4'h6, 1'b1);
      for (int i = 0; i < 6; i++) strobe(1'b0, 1'b1, 4'(i), 1'b0);
      chk("noise_abort_count", abort_cnt - base_ab, 32'd1);
      chk("noise_err_count", err_count, 32'd4);
      send_frame(4'h1, 24'hABCDEF, crc_model(24'hABCDEF), 1'b1, 1'b1);
      chk("noise_clean_err_count", err_count, 32'd4);

      // Saturation on the narrow-counter instance
      @(negedge clk_rx); reset = 1'b1;
      @(negedge clk_rx); reset = 1'b0;
      chk("sat_pre_err_count", s_err_count, 32'd0);
      for (int i = 0; i < 5; i++) send_frame(4'h1, 24'h000001, 4'h9, 1'b0, 1'b1);
      chk("sat_err_count_w2", s_err_count, 32'd3);
      chk("sat_err_count_w8", err_count, 32'd5);
      chk("sat_crc_ok", s_crc_ok, 32'd0);

      // Asynchronous reset in the middle of DATA
      base_ab = abort_cnt;
      strobe(1'b1, 1'b0, 4'h0, 1'b0);
      strobe(1'b0, 1'b1, 4'h2, 1'b0);
      strobe(1'b0, 1'b1, 4'h3, 1'b0);
      strobe(1'b0, 1'b1, 4'h4, 1'b0);
      @(posedge clk_rx);
      #2 reset = 1'b1;
      #1 chk_all_zero("async_reset");
      repeat (2) begin
         @(negedge clk_rx);
         chk("async_reset_no_abort", frame_abort, 32'd0);
      end
      reset = 1'b0;
      repeat (3) @(negedge clk_rx);
      chk("post_reset_abort_count", abort_cnt - base_ab, 32'd0);
      send_frame(vecs[1].status, vecs[1].data, vecs[1].crc, vecs[1].ok, 1'b1);
      chk("post_reset_err_count", err_count, 32'd0);

      repeat (3) @(negedge clk_rx);
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
